latency_fifo: RTL

Synchronous single-clock FIFO with behavioural storage, replacing vendor-macro FIFOs where portability matters. Adds a parametrised read latency, a `pop_valid` strobe, an occupancy count and sticky overflow/underflow flags. Keeps the latency-aware `may_push` back-pressure needed by producers that react late. It sits between pipelined stages and inter-module stream ports.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/latency_pipe.sv | 46 ++++
 rtl/latency_fifo.sv | 98 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the latency-aware FIFO: pointer sizing and the
// back-pressure threshold derived from producer reaction latency.
package fifo_pkg;

  // Pointer width including the wrap bit that separates full from empty.
  function automatic int fifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy below which the producer may keep pushing, leaving room for
  // every push already in flight when may_push falls.
  function automatic int fifo_push_thresh(input int depth, input int lat, input int extra);
    return depth - lat - extra;
  endfunction

endpackage

// File: rtl/latency_pipe.sv
// Valid/data shift register that adds fixed latency after the array read.
// Clear zeroes only the valid bits; data registers load only with a token.
module latency_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is order-free.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/latency_fifo.sv
// Single-clock FIFO with behavioural storage, configurable read latency,
// occupancy count, sticky error flags and latency-aware push back-pressure.
module latency_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int DEPTH            = 32,
  parameter int READ_LATENCY     = 2,
  parameter int MAY_PUSH_LATENCY = 5,
  parameter int EXTRA_IN_FLIGHT  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   may_push,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   may_pop,
  input  logic                   pop,
  output logic                   pop_valid,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = fifo_ptr_width(DEPTH);
  localparam int THRESH = fifo_push_thresh(DEPTH, MAY_PUSH_LATENCY, EXTRA_IN_FLIGHT);

  if (THRESH < 1) begin : g_bad_thresh
    $error("latency_fifo: MAY_PUSH_LATENCY + EXTRA_IN_FLIGHT leaves no push headroom");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("latency_fifo: DEPTH must be a power of two and at least 4");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("latency_fifo: READ_LATENCY must be 1..3");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push_ok, pop_ok;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             pipe_valid;
  logic [WIDTH-1:0] pipe_data;
  logic             seen_q;

  // The wrap bit makes the pointer difference equal the true occupancy.
  assign count    = wptr - rptr;
  assign push_ok  = push && (count != PW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign may_push = count < PW'(THRESH);
  assign may_pop  = count != '0;

  // NOTE: the storage array and the read register carry no reset; their
  // contents are only observed behind pointers and valid bits that are reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    if (pop_ok)  rd_data_q <= mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      rd_valid_q <= pop_ok;
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
      if (pipe_valid)       seen_q    <= 1'b1;
    end
  end

  latency_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (READ_LATENCY - 1)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_q),
    .in_data   (rd_data_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // Output reads zero until the first entry emerges after reset, then
  // holds the most recent popped entry between strobes.
  assign pop_valid = pipe_valid;
  assign pop_data  = (seen_q || pipe_valid) ? pipe_data : '0;

endmodule
